btn_debounce_repeat: RTL and testbench

- Input-side companion to the counter/display path: conditions raw active-low push buttons into clean, clk-synchronous events.
- Per button it synchronizes, inverts and debounces the pin, then emits one-cycle press, release and auto-repeat pulses.
- A counter block consumes these pulses directly, replacing free-running sampling of raw button pins.

---
 rtl/btn_debounce_repeat.sv | 146 ++++++++++++++
 tb/tb_btn_debounce_repeat.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_repeat.sv
// btn_debounce_repeat: turns raw active-low push buttons into clean,
// clk-synchronous level, press, release and auto-repeat events.
// Each button is an independent lane: 2-flop synchronizer, debounce
// counter, edge pulses and a repeat timer FSM.
//
// Handshake: none. Every output is a registered level or one-cycle pulse
// that a consumer samples on any clk edge; there is no valid/ready.
module btn_debounce_repeat #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] nbtn,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic [N-1:0] btn_repeat
);

  // Counter widths hold 0 .. terminal-1; never narrower than one bit.
  localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rep_state_e;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic            sync1_q;
    logic            sync2_q;
    logic            raw;
    logic            stable_q;
    logic [CW-1:0]   cnt_q;
    logic            flip_d;
    logic            rise_d;
    logic            fall_d;
    logic            press_q;
    logic            release_q;
    logic            repeat_q;
    rep_state_e      state_q;
    logic [TW-1:0]   timer_q;

    // Two-flop synchronizer; resets to the released (high) pin level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= nbtn[i];
        sync2_q <= sync1_q;
      end
    end

    assign raw    = ~sync2_q;
    assign flip_d = (raw != stable_q) && (cnt_q == DB_LAST);
    assign rise_d = flip_d & raw;
    assign fall_d = flip_d & ~raw;

    // Debounce: any cycle where raw agrees with stable restarts the count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else if (raw == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        stable_q <= raw;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    // Press/release pulses land in the same cycle the new level appears.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= rise_d;
        release_q <= fall_d;
      end
    end

    // Repeat FSM: a release flip wins over a timer expiry on the same edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= ST_IDLE;
        timer_q  <= '0;
        repeat_q <= 1'b0;
      end else begin
        repeat_q <= 1'b0;
        if (fall_d) begin
          state_q <= ST_IDLE;
          timer_q <= '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (rise_d) begin
                state_q <= ST_DELAY;
                timer_q <= '0;
              end
            end
            ST_DELAY: begin
              if (timer_q == DELAY_LAST) begin
                repeat_q <= 1'b1;
                state_q  <= ST_REPEAT;
                timer_q  <= '0;
              end else begin
                timer_q <= timer_q + TW'(1);
              end
            end
            ST_REPEAT: begin
              if (timer_q == RATE_LAST) begin
                repeat_q <= 1'b1;
                timer_q  <= '0;
              end else begin
                timer_q <= timer_q + TW'(1);
              end
            end
            default: begin
              state_q <= ST_IDLE;
              timer_q <= '0;
            end
          endcase
        end
      end
    end

    assign btn_level[i]   = stable_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_repeat[i]  = repeat_q;
  end

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Directed testbench for btn_debounce_repeat with short timing parameters.
// Outputs are compared as one packed vector {level, press, release, repeat}
// sampled 1 time unit after each rising clock edge. Edge numbers in the
// tests count rising edges after the pin change was driven.
module tb_btn_debounce_repeat;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] nbtn;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;

  int n_checks = 0;
  int n_fail   = 0;

  btn_debounce_repeat #(
    .N               (N),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .nbtn        (nbtn),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold all buttons released for n cycles so every lane settles idle.
  task automatic idle(input int n);
    nbtn = 4'b1111;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    logic [15:0] got;
    rst  = 1'b1;
    nbtn = 4'b1111;
    repeat (3) tick();
    n_checks++;
    got = {btn_level, btn_press, btn_release, btn_repeat};
    if (got !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_init: got %h expected %h", got, 16'h0000);
    end
    rst = 1'b0;
    idle(4);
    // All four pressed; flip lands on edge 6.
    nbtn = 4'b0000;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = {(e >= 6) ? 4'hF : 4'h0, (e == 6) ? 4'hF : 4'h0, 4'h0, 4'h0};
      got = {btn_level, btn_press, btn_release, btn_repeat};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_prehold edge %0d: got %h expected %h", e, got, exp);
      end
    end
    // Mid-cycle async reset while held: outputs clear with no clock edge.
    #3 rst = 1'b1;
    #1;
    got = {btn_level, btn_press, btn_release, btn_repeat};
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", got, 16'h0000);
    end
    tick();
    got = {btn_level, btn_press, btn_release, btn_repeat};
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", got, 16'h0000);
    end
    #4 rst = 1'b0;
    // Still held: fresh debounce and fresh press 6 edges after deassert.
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = {(e >= 6) ? 4'hF : 4'h0, (e == 6) ? 4'hF : 4'h0, 4'h0, 4'h0};
      got = {btn_level, btn_press, btn_release, btn_repeat};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_rehold edge %0d: got %h expected %h", e, got, exp);
      end
    end
    // Release after edge 8: release flip at edge 14, before any repeat (16).
    nbtn = 4'b1111;
    for (int e = 9; e <= 16; e++) begin
      tick();
      exp = {(e < 14) ? 4'hF : 4'h0, 4'h0, (e == 14) ? 4'hF : 4'h0, 4'h0};
      got = {btn_level, btn_press, btn_release, btn_repeat};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: got %h expected %h", e, got, exp);
      end
    end
    idle(3);
  endtask

  task automatic test_clean_press();
    logic [15:0] exp;
    logic [15:0] got;
    nbtn = 4'b1110;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 7) nbtn = 4'b1111;  // release flip lands on edge 13
      exp = {(e >= 6 && e < 13) ? 4'h1 : 4'h0, (e == 6) ? 4'h1 : 4'h0,
             (e == 13) ? 4'h1 : 4'h0, 4'h0};
      got = {btn_level, btn_press, btn_release, btn_repeat};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL clean_press edge %0d: got %h expected %h", e, got, exp);
      end
    end
    idle(3);
  endtask

  task automatic test_bounce();
    logic [15:0] got;
    // Low 3 cycles, high 1 cycle: counter reaches DB-1 but never flips.
    for (int c = 0; c < 20; c++) begin
      nbtn = ((c % 4) != 3) ? 4'b1101 : 4'b1111;
      tick();
      got = {btn_level, btn_press, btn_release, btn_repeat};
      n_checks++;
      if (got !== 16'h0000) begin
        n_fail++;
        $display("FAIL bounce cycle %0d: got %h expected %h", c, got, 16'h0000);
      end
    end
    nbtn = 4'b1111;
    for (int c = 20; c < 26; c++) begin
      tick();
      got = {btn_level, btn_press, btn_release, btn_repeat};
      n_checks++;
      if (got !== 16'h0000) begin
        n_fail++;
        $display("FAIL bounce_tail cycle %0d: got %h expected %h", c, got, 16'h0000);
      end
    end
    idle(2);
  endtask

  task automatic test_auto_repeat();
    logic [15:0] exp;
    logic [15:0] got;
    logic        rep;
    // Press flip P=6: repeats at 16,19,22,25; release flip at 27 pre-empts 28.
    nbtn = 4'b1011;
    for (int e = 1; e <= 36; e++) begin
      tick();
      if (e == 21) nbtn = 4'b1111;
      rep = (e == 16) || (e == 19) || (e == 22) || (e == 25);
      exp = {(e >= 6 && e < 27) ? 4'h4 : 4'h0, (e == 6) ? 4'h4 : 4'h0,
             (e == 27) ? 4'h4 : 4'h0, rep ? 4'h4 : 4'h0};
      got = {btn_level, btn_press, btn_release, btn_repeat};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL auto_repeat edge %0d: got %h expected %h", e, got, exp);
      end
    end
    idle(3);
  endtask

  task automatic test_release_at_terminal();
    logic [15:0] exp;
    logic [15:0] got;
    // Press flip 6; DELAY timer hits 9 at edge 16, same edge as release flip.
    nbtn = 4'b1101;
    for (int e = 1; e <= 26; e++) begin
      tick();
      if (e == 10) nbtn = 4'b1111;
      exp = {(e >= 6 && e < 16) ? 4'h2 : 4'h0, (e == 6) ? 4'h2 : 4'h0,
             (e == 16) ? 4'h2 : 4'h0, 4'h0};
      got = {btn_level, btn_press, btn_release, btn_repeat};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL release_terminal edge %0d: got %h expected %h", e, got, exp);
      end
    end
    idle(3);
  endtask

  task automatic test_independence();
    logic [15:0] exp;
    logic [15:0] got;
    logic [3:0]  lvl;
    logic [3:0]  prs;
    logic [3:0]  rls;
    logic [3:0]  rep;
    // Lane 0 press flip at 6, lane 3 at 8; both release flips at 30.
    nbtn = 4'b1110;
    for (int e = 1; e <= 36; e++) begin
      tick();
      if (e == 2)  nbtn = 4'b0110;
      if (e == 24) nbtn = 4'b1111;
      lvl = {(e >= 8 && e < 30), 2'b00, (e >= 6 && e < 30)};
      prs = {(e == 8), 2'b00, (e == 6)};
      rls = (e == 30) ? 4'b1001 : 4'b0000;
      rep = {(e >= 18 && e < 30 && ((e - 18) % 3) == 0), 2'b00,
             (e >= 16 && e < 30 && ((e - 16) % 3) == 0)};
      exp = {lvl, prs, rls, rep};
      got = {btn_level, btn_press, btn_release, btn_repeat};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL independence edge %0d: got %h expected %h", e, got, exp);
      end
    end
    idle(3);
  endtask

  initial begin
    rst  = 1'b1;
    nbtn = 4'b1111;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_release_at_terminal();
    test_independence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
